mfp_srec_parser: RTL and testbench

Upstream feeder of the AHB loader stage. Consumes a stream of ASCII characters from the UART receiver and decodes Motorola S-records (S0–S3, S5, S7–S9). Emits one write_address/write_byte/write_enable strobe per data byte of S1/S2/S3 records. Flags malformed input and checksum mismatches, and reports whether a download is in progress.

---
 rtl/mfp_srec_parser_pkg.sv | 53 +++++
 rtl/mfp_hex_char_decoder.sv | 30 +++
 rtl/mfp_srec_parser.sv | 235 +++++++++++++++++++++++
 tb/tb_mfp_srec_parser.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mfp_srec_parser_pkg.sv
// rtl/mfp_srec_parser_pkg.sv - shared constants, FSM encoding and record-type helpers for the S-record parser
//
// Holds the ASCII characters the parser recognises, the parser state encoding,
// the checksum target and small lookups that classify a record type character.

package mfp_srec_parser_pkg;

    // ASCII characters of interest
    localparam logic [7:0] CHAR_S       = 8'h53;
    localparam logic [7:0] CHAR_CR      = 8'h0D;
    localparam logic [7:0] CHAR_LF      = 8'h0A;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_ZERO    = 8'h30;
    localparam logic [7:0] CHAR_NINE    = 8'h39;
    localparam logic [7:0] CHAR_UPPER_A = 8'h41;
    localparam logic [7:0] CHAR_UPPER_F = 8'h46;
    localparam logic [7:0] CHAR_LOWER_A = 8'h61;
    localparam logic [7:0] CHAR_LOWER_F = 8'h66;

    // count + address + data + checksum bytes must sum to this value
    localparam logic [7:0] CHECKSUM_TARGET = 8'hFF;

    typedef enum logic [2:0] {
        ST_WAIT_S = 3'd0,
        ST_TYPE   = 3'd1,
        ST_COUNT  = 3'd2,
        ST_ADDR   = 3'd3,
        ST_DATA   = 3'd4,
        ST_CSUM   = 3'd5
    } state_t;

    // Address field length in bytes for a record type character; 0 means the
    // type is not supported and must be treated as malformed input.
    function automatic logic [2:0] record_addr_len(input logic [7:0] c);
        case (c)
            8'h30, 8'h31, 8'h35, 8'h39: return 3'd2;   // S0 S1 S5 S9
            8'h32, 8'h38:               return 3'd3;   // S2 S8
            8'h33, 8'h37:               return 3'd4;   // S3 S7
            default:                    return 3'd0;
        endcase
    endfunction

    // S1/S2/S3 carry bytes that are written to memory
    function automatic logic record_is_data(input logic [7:0] c);
        return (c == 8'h31) || (c == 8'h32) || (c == 8'h33);
    endfunction

    // S7/S8/S9 terminate a download
    function automatic logic record_is_term(input logic [7:0] c);
        return (c == 8'h37) || (c == 8'h38) || (c == 8'h39);
    endfunction

endpackage

// File: rtl/mfp_hex_char_decoder.sv
// rtl/mfp_hex_char_decoder.sv - combinational ASCII hex digit to nibble decoder
//
// Ports:
//   char_data  8-bit ASCII character
//   nibble     decoded 4-bit value (0 when not a hex digit)
//   is_hex     1 when char_data is 0-9, A-F or a-f

module mfp_hex_char_decoder
    import mfp_srec_parser_pkg::*;
(
    input  logic [7:0] char_data,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'd0;
        is_hex = 1'b0;
        if (char_data >= CHAR_ZERO && char_data <= CHAR_NINE) begin
            is_hex = 1'b1;
            nibble = char_data[3:0];
        end else if ((char_data >= CHAR_UPPER_A && char_data <= CHAR_UPPER_F) ||
                     (char_data >= CHAR_LOWER_A && char_data <= CHAR_LOWER_F)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            is_hex = 1'b1;
            nibble = char_data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/mfp_srec_parser.sv
// rtl/mfp_srec_parser.sv - Motorola S-record decoder producing byte write strobes
//
// Ports:
//   clock          system clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   char_data      received ASCII character
//   char_ready     one-cycle strobe qualifying char_data (may be high every cycle)
//   write_address  byte address of the current data byte
//   write_byte     data byte
//   write_enable   one-cycle strobe qualifying write_address/write_byte
//   in_progress    download active
//   format_error   sticky malformed-input / checksum flag, cleared only by reset

module mfp_srec_parser
    import mfp_srec_parser_pkg::*;
#(
    parameter int IDLE_TIMEOUT  = 50000000,
    parameter int TIMEOUT_WIDTH = 26
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  char_data,
    input  logic        char_ready,
    output logic [31:0] write_address,
    output logic [7:0]  write_byte,
    output logic        write_enable,
    output logic        in_progress,
    output logic        format_error
);

    state_t state, state_nxt;

    logic [3:0]  nibble;
    logic        is_hex;
    logic        phase;       // 1 once the high nibble of a byte has been captured
    logic [3:0]  hi_nib;
    logic [7:0]  rx_byte;
    logic [2:0]  addr_len;
    logic [2:0]  addr_idx;
    logic [7:0]  remain;      // bytes of the record still to come, including this one
    logic [7:0]  sum;
    logic [31:0] cur_addr;
    logic        data_rec;
    logic        term_rec;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;

    logic        hex_field;
    logic        byte_done;
    logic        bad_char;
    logic        short_count;
    logic        csum_ok;
    logic        timeout_hit;
    logic        fsm_error;
    logic [2:0]  type_len;

    mfp_hex_char_decoder u_hex (
        .char_data (char_data),
        .nibble    (nibble),
        .is_hex    (is_hex)
    );

    assign rx_byte     = {hi_nib, nibble};
    assign hex_field   = (state == ST_COUNT) || (state == ST_ADDR) ||
                         (state == ST_DATA)  || (state == ST_CSUM);
    assign byte_done   = char_ready && is_hex && phase && hex_field;
    assign bad_char    = char_ready && !is_hex && hex_field;
    assign short_count = rx_byte < ({5'd0, addr_len} + 8'd1);
    assign csum_ok     = (sum + rx_byte) == CHECKSUM_TARGET;
    assign type_len    = record_addr_len(char_data);
    assign timeout_hit = !char_ready && (idle_cnt == TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT_S;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fsm_error = 1'b0;
        case (state)
            ST_WAIT_S: begin
                // line endings, blanks and any other noise between records are skipped
                if (char_ready && char_data == CHAR_S) begin
                    state_nxt = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (char_ready) begin
                    if (type_len != 3'd0) begin
                        state_nxt = ST_COUNT;
                    end else begin
                        fsm_error = 1'b1;
                    end
                end
            end
            ST_COUNT: begin
                if (byte_done) begin
                    if (short_count) begin
                        fsm_error = 1'b1;
                    end else begin
                        state_nxt = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                // remain == 2 on the last address byte means only the checksum follows
                if (byte_done && addr_idx == addr_len - 3'd1) begin
                    state_nxt = (remain == 8'd2) ? ST_CSUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_done && remain == 8'd2) begin
                    state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_done) begin
                    state_nxt = ST_WAIT_S;
                end
            end
            default: begin
                state_nxt = ST_WAIT_S;
            end
        endcase
        if (bad_char) begin
            fsm_error = 1'b1;
        end
        if (fsm_error) begin
            state_nxt = ST_WAIT_S;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (char_ready) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_WIDTH'(IDLE_TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase         <= 1'b0;
            hi_nib        <= 4'd0;
            addr_len      <= 3'd0;
            addr_idx      <= 3'd0;
            remain        <= 8'd0;
            sum           <= 8'd0;
            cur_addr      <= 32'd0;
            data_rec      <= 1'b0;
            term_rec      <= 1'b0;
            write_address <= 32'd0;
            write_byte    <= 8'd0;
            write_enable  <= 1'b0;
            in_progress   <= 1'b0;
            format_error  <= 1'b0;
        end else begin
            write_enable <= 1'b0;

            if (fsm_error) begin
                phase        <= 1'b0;
                format_error <= 1'b1;
            end else if (char_ready && is_hex && hex_field) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_nib <= nibble;
                end
            end

            case (state)
                ST_WAIT_S: begin
                    if (char_ready && char_data == CHAR_S) begin
                        in_progress <= 1'b1;
                    end
                end
                ST_TYPE: begin
                    if (char_ready && type_len != 3'd0) begin
                        addr_len <= type_len;
                        data_rec <= record_is_data(char_data);
                        term_rec <= record_is_term(char_data);
                    end
                end
                ST_COUNT: begin
                    if (byte_done && !fsm_error) begin
                        remain   <= rx_byte;
                        sum      <= rx_byte;
                        addr_idx <= 3'd0;
                        cur_addr <= 32'd0;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        sum      <= sum + rx_byte;
                        remain   <= remain - 8'd1;
                        addr_idx <= addr_idx + 3'd1;
                        cur_addr <= {cur_addr[23:0], rx_byte};
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        sum    <= sum + rx_byte;
                        remain <= remain - 8'd1;
                        if (data_rec) begin
                            write_enable  <= 1'b1;
                            write_address <= cur_addr;
                            write_byte    <= rx_byte;
                            cur_addr      <= cur_addr + 32'd1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (byte_done) begin
                        if (!csum_ok) begin
                            format_error <= 1'b1;
                        end else if (term_rec) begin
                            in_progress <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (timeout_hit) begin
                in_progress <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mfp_srec_parser.sv
// tb/tb_mfp_srec_parser.sv - directed self-checking bench for mfp_srec_parser

module tb_mfp_srec_parser;

    localparam int IDLE = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  char_data = 8'd0;
    logic        char_ready = 1'b0;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        write_enable;
    logic        in_progress;
    logic        format_error;

    int n_total = 0;
    int n_pass = 0;
    int adjacent_we = 0;
    logic we_prev = 1'b0;
    logic [39:0] wq[$];

    mfp_srec_parser #(
        .IDLE_TIMEOUT  (IDLE),
        .TIMEOUT_WIDTH (6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .char_data     (char_data),
        .char_ready    (char_ready),
        .write_address (write_address),
        .write_byte    (write_byte),
        .write_enable  (write_enable),
        .in_progress   (in_progress),
        .format_error  (format_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (write_enable) wq.push_back({write_address, write_byte});
        if (write_enable && we_prev) adjacent_we++;
        we_prev = write_enable;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [7:0] b);
        logic [39:0] got;
        got = 'x;
        if (idx < wq.size()) got = wq[idx];
        check(tag, got, {a, b});
    endtask

    task automatic send_char(input logic [7:0] c);
        char_data = c;
        char_ready = 1'b1;
        @(negedge clock);
        char_ready = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic check_rec1(input string tag);
        check({tag, "_count"}, 40'(wq.size()), 40'd4);
        check_write({tag, "_w0"}, 0, 32'h0000_0010, 8'h12);
        check_write({tag, "_w1"}, 1, 32'h0000_0011, 8'h34);
        check_write({tag, "_w2"}, 2, 32'h0000_0012, 8'h56);
        check_write({tag, "_w3"}, 3, 32'h0000_0013, 8'h78);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_we",   40'(write_enable),  40'd0);
        check("rst_addr", 40'(write_address), 40'd0);
        check("rst_byte", 40'(write_byte),    40'd0);
        check("rst_ip",   40'(in_progress),   40'd0);
        check("rst_fe",   40'(format_error),  40'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // basic S1 record
        wq.delete();
        send_str("S107001012345678D4\r\n");
        check_rec1("c1");
        check("c1_fe", 40'(format_error), 40'd0);
        check("c1_ip", 40'(in_progress),  40'd1);

        // lowercase 's' is noise; S3 with lowercase hex
        wq.delete();
        send_str("s3S30900000100aabbccdde7\r\n");
        check("c2_count", 40'(wq.size()), 40'd4);
        check_write("c2_w0", 0, 32'h0000_0100, 8'hAA);
        check_write("c2_w1", 1, 32'h0000_0101, 8'hBB);
        check_write("c2_w2", 2, 32'h0000_0102, 8'hCC);
        check_write("c2_w3", 3, 32'h0000_0103, 8'hDD);
        check("c2_fe", 40'(format_error), 40'd0);

        // 32-bit address wrap
        wq.delete();
        send_str("S307FFFFFFFF1122C9");
        check("wrap_count", 40'(wq.size()), 40'd2);
        check_write("wrap_w0", 0, 32'hFFFF_FFFF, 8'h11);
        check_write("wrap_w1", 1, 32'h0000_0000, 8'h22);
        check("wrap_fe", 40'(format_error), 40'd0);

        // terminator drops in_progress after its last checksum char
        wq.delete();
        send_str("S9030000F");
        check("term_ip_before", 40'(in_progress), 40'd1);
        send_str("C");
        check("term_ip_after", 40'(in_progress), 40'd0);
        check("term_nowrite", 40'(wq.size()), 40'd0);
        check("term_fe", 40'(format_error), 40'd0);

        // idle timeout
        send_str("S");
        check("to_ip_set", 40'(in_progress), 40'd1);
        repeat (IDLE - 1) @(negedge clock);
        check("to_ip_before", 40'(in_progress), 40'd1);
        @(negedge clock);
        check("to_ip_at", 40'(in_progress), 40'd0);
        // complete that record as an S1 with no data: no writes, no error
        wq.delete();
        send_str("1030000FC");
        check("s1empty_nowrite", 40'(wq.size()), 40'd0);
        check("s1empty_fe", 40'(format_error), 40'd0);
        check("s1empty_ip", 40'(in_progress), 40'd0);

        // bad checksum: writes happen, error flags after last char, sticky
        wq.delete();
        send_str("S107001012345678D");
        check("c3_fe_before", 40'(format_error), 40'd0);
        send_str("5");
        check("c3_fe_after", 40'(format_error), 40'd1);
        check_rec1("c3");
        wq.delete();
        send_str("\r\nS107001012345678D4");
        check_rec1("c3_next");
        check("c3_fe_sticky", 40'(format_error), 40'd1);

        // malformed hex mid-address
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wq.delete();
        send_str("S107001G");
        check("c4_fe", 40'(format_error), 40'd1);
        check("c4_nowrite", 40'(wq.size()), 40'd0);
        send_str("\r\nS107001012345678D4");
        check_rec1("c4_resync");

        // reset mid-DATA
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wq.delete();
        send_str("S1070010123");
        check("c6_partial", 40'(wq.size()), 40'd1);
        reset_n = 1'b0;
        #1;
        check("c6_we",   40'(write_enable),  40'd0);
        check("c6_addr", 40'(write_address), 40'd0);
        check("c6_byte", 40'(write_byte),    40'd0);
        check("c6_ip",   40'(in_progress),   40'd0);
        check("c6_fe",   40'(format_error),  40'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wq.delete();
        send_str("S107001012345678D4");
        check_rec1("c6_after");
        check("c6_fe_after", 40'(format_error), 40'd0);
        check("we_adjacent", 40'(adjacent_we), 40'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
